instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Program-counter and fetch stage sitting directly upstream of the instruction memory.
- Drives the 10-bit word address into the memory and captures the returned 32-bit word into an IF/ID register for decode.
- Applies stall, branch and jump redirects from decode.
- Selects one of four program entry points on start, and halts on address-space overrun.

Parameters:
- ADDR_W, 10, PC / memory word-address width.
- MEM_DEPTH, 81, number of valid instruction words; PC >= MEM_DEPTH is out of range.
- PROG0_BASE, 0, entry address for prog_sel=0 (factorial).
- PROG1_BASE, 10, entry address for prog_sel=1 (fibonacci).
- PROG2_BASE, 21, entry address for prog_sel=2 (tests).
- PROG3_BASE, 0, entry address for prog_sel=3.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  pulse; loads entry PC and begins fetching (IDLE/HALT only).
- prog_sel  in  2  entry-point select, sampled with start.
- stall  in  1  hold PC and IF/ID register.
- branch_taken  in  1  decode resolved a taken beq/bne for the instruction in instr_out.
- branch_offset  in  16  signed word offset, instruction[15:0].
- jump  in  1  decode holds a jump in instr_out.
- jump_target  in  26  instruction[25:0]; low ADDR_W bits used as absolute target.
- instrucao  in  32  word returned combinationally by instruction memory for address.
- address  out  10  PC driven to instruction memory.
- instr_out  out  32  IF/ID instruction register.
- pc_out  out  10  address of instr_out.
- valid  out  1  instr_out holds a live instruction.
- busy  out  1  state == FETCH.
- halted  out  1  state == HALT.

Behaviour:
- One clock. Reset is synchronous, active-low: reset_n low at a rising edge clears all state.
- Reset values: pc=0, address=0, instr_out=0, pc_out=0, valid=0, busy=0, halted=0, state=IDLE.
- address is the PC register directly, with no combinational path from inputs. The memory read is combinational, so instrucao corresponds to address in the same cycle.
- States: IDLE, FETCH, HALT.
- IDLE:
  - valid=0.
  - On start: pc <= PROGn_BASE per prog_sel, go to FETCH.
  - First valid instruction appears one cycle after the first FETCH cycle.
- FETCH, per edge, in priority order:
  1. reset.
  2. jump: pc <= jump_target[ADDR_W-1:0]; valid <= 0 (one-bubble flush). instr_out is not updated.
  3. branch_taken: pc <= pc_out + 1 + sign_extend(branch_offset), truncated to ADDR_W (wraps modulo 2^ADDR_W); valid <= 0.
  4. stall: pc, instr_out, pc_out and valid hold.
  5. Otherwise: instr_out <= instrucao; pc_out <= pc; valid <= 1; pc <= pc+1.
- Redirect vs stall: a redirect overrides stall in the same cycle.
- jump and branch_taken together: jump wins.
- Redirect/stall inputs are ignored while valid=0, except stall, which is always honoured in FETCH.
- Halt on overrun:
  - If a normal advance would load pc = MEM_DEPTH, the last word is still captured (valid=1 that cycle).
  - The next edge enters HALT with valid <= 0; pc holds MEM_DEPTH.
  - A redirect target >= MEM_DEPTH enters HALT on the same edge, with valid <= 0.
- HALT: halted=1, valid=0, outputs hold. start restarts exactly as from IDLE.
- start while in FETCH is ignored.
- Reset mid-operation: any state returns to IDLE with reset values on that edge; in-flight instruction discarded.

Optional Feature:
- Macro IFETCH_PERF_COUNT_EN.
- Defined:
  - Adds output ports fetch_count[15:0] (increments on each edge where valid is loaded with 1) and bubble_count[15:0] (increments on each redirect and each stalled FETCH cycle).
  - Both saturate at 16'hFFFF and clear on reset and on start.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Reset then start with prog_sel=0, no stalls:
  - address 0,1,2,... on successive cycles.
  - valid rises one cycle after FETCH entry.
  - instr_out=32'hABC00000 with pc_out=0, then pc_out=1, 2.
- prog_sel=1 start:
  - first fetch address=10.
  - With decode asserting jump (jump_target=15) while pc_out=20: next address=15, valid=0 for exactly one cycle, then instr_out from address 15.
- Branch: pc_out=6, branch_taken=1, branch_offset=16'h0015:
  - next address=28, one bubble.
  - Also branch_offset=16'hFFFE at pc_out=6: next address=5.
- Stall held 3 cycles during FETCH:
  - address, instr_out and pc_out constant; valid unchanged.
  - Resumes at pc+1 after release.
  - Stall + jump in the same cycle: jump taken.
- Overrun, MEM_DEPTH=81, fetch reaches address 80:
  - word 80 delivered with valid=1.
  - Then halted=1, valid=0.
  - start with prog_sel=2 restarts at 21.
- reset_n low for one cycle during FETCH at address 7:
  - all outputs return to reset values on that edge; state IDLE; no fetch until start.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: start/entry select, decode redirect/stall controls,
// the instruction-memory address/data pair and the IF/ID register outputs.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [1:0]        prog_sel;
    logic              stall;
    logic              branch_taken;
    logic [15:0]       branch_offset;
    logic              jump;
    logic [25:0]       jump_target;
    logic [31:0]       instrucao;
    logic [ADDR_W-1:0] address;
    logic [31:0]       instr_out;
    logic [ADDR_W-1:0] pc_out;
    logic              valid;
    logic              busy;
    logic              halted;

    modport master (
        input  start, prog_sel, stall, branch_taken, branch_offset,
               jump, jump_target, instrucao,
        output address, instr_out, pc_out, valid, busy, halted
    );

    modport slave (
        output start, prog_sel, stall, branch_taken, branch_offset,
               jump, jump_target, instrucao,
        input  address, instr_out, pc_out, valid, busy, halted
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC + IF/ID fetch stage: one instruction per cycle, one bubble per redirect,
// stall holds PC and IF/ID. Optional perf counters under IFETCH_PERF_COUNT_EN.
module instruction_fetch_unit #(
    parameter int ADDR_W     = 10,
    parameter int MEM_DEPTH  = 81,
    parameter int PROG0_BASE = 0,
    parameter int PROG1_BASE = 10,
    parameter int PROG2_BASE = 21,
    parameter int PROG3_BASE = 0
) (
    input  logic                      clock,
    input  logic                      reset_n,
    instruction_fetch_unit_if.master  bus
`ifdef IFETCH_PERF_COUNT_EN
    ,
    output logic [15:0]               fetch_count,
    output logic [15:0]               bubble_count
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] BASE0 = ADDR_W'(PROG0_BASE);
    localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(PROG1_BASE);
    localparam logic [ADDR_W-1:0] BASE2 = ADDR_W'(PROG2_BASE);
    localparam logic [ADDR_W-1:0] BASE3 = ADDR_W'(PROG3_BASE);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] pc_out_q, pc_out_nxt;
    logic [31:0]       instr_q, instr_nxt;
    logic              valid_q, valid_nxt;
    logic [ADDR_W-1:0] entry_pc, branch_pc, redirect_pc;
    logic              redirect, stalled, fetched, restart;

    always_comb begin
        case (bus.prog_sel)
            2'd0:    entry_pc = BASE0;
            2'd1:    entry_pc = BASE1;
            2'd2:    entry_pc = BASE2;
            default: entry_pc = BASE3;
        endcase
    end

    // Low bits of the sign-extended offset suffice: the sum wraps modulo 2^ADDR_W.
    assign branch_pc   = pc_out_q + ADDR_W'(1) + bus.branch_offset[ADDR_W-1:0];
    assign redirect_pc = bus.jump ? bus.jump_target[ADDR_W-1:0] : branch_pc;

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        pc_out_nxt = pc_out_q;
        instr_nxt  = instr_q;
        valid_nxt  = valid_q;
        redirect   = 1'b0;
        stalled    = 1'b0;
        fetched    = 1'b0;
        restart    = 1'b0;
        case (state)
            IDLE, HALT: begin
                valid_nxt = 1'b0;
                if (bus.start) begin
                    restart   = 1'b1;
                    pc_nxt    = entry_pc;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                // Redirects only act on a live instruction in the IF/ID register.
                if (valid_q && (bus.jump || bus.branch_taken)) begin
                    redirect  = 1'b1;
                    pc_nxt    = redirect_pc;
                    valid_nxt = 1'b0;
                    if ({1'b0, redirect_pc} >= DEPTH)
                        state_nxt = HALT;
                end else if (bus.stall) begin
                    stalled = 1'b1;
                end else if ({1'b0, pc} >= DEPTH) begin
                    valid_nxt = 1'b0;
                    state_nxt = HALT;
                end else begin
                    fetched    = 1'b1;
                    instr_nxt  = bus.instrucao;
                    pc_out_nxt = pc;
                    valid_nxt  = 1'b1;
                    pc_nxt     = pc + ADDR_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            pc       <= '0;
            pc_out_q <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            pc_out_q <= pc_out_nxt;
            instr_q  <= instr_nxt;
            valid_q  <= valid_nxt;
        end
    end

    assign bus.address   = pc;
    assign bus.instr_out = instr_q;
    assign bus.pc_out    = pc_out_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = (state == FETCH);
    assign bus.halted    = (state == HALT);

`ifdef IFETCH_PERF_COUNT_EN
    always_ff @(posedge clock) begin
        if (!reset_n || restart) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (fetched && fetch_count != 16'hFFFF)
                fetch_count <= fetch_count + 16'd1;
            if ((redirect || stalled) && bubble_count != 16'hFFFF)
                bubble_count <= bubble_count + 16'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = restart ^ redirect ^ stalled ^ fetched;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table plus hand-written
// sequences for reset, long runs, overrun halt and restart.
module tb_instruction_fetch_unit;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    instruction_fetch_unit_if #(.ADDR_W(10)) bus();

`ifdef IFETCH_PERF_COUNT_EN
    logic [15:0] fetch_count, bubble_count;
    instruction_fetch_unit dut (
        .clock(clock), .reset_n(reset_n), .bus(bus),
        .fetch_count(fetch_count), .bubble_count(bubble_count)
    );
`else
    instruction_fetch_unit dut (
        .clock(clock), .reset_n(reset_n), .bus(bus)
    );
`endif

    function automatic logic [31:0] memword(input logic [9:0] a);
        return 32'hABC00000 | {22'd0, a};
    endfunction

    assign bus.instrucao = memword(bus.address);

    typedef struct {
        logic        start;
        logic [1:0]  sel;
        logic        stall;
        logic        br;
        logic [15:0] off;
        logic        jmp;
        logic [9:0]  jt;
        logic        ca;
        logic [9:0]  addr;
        logic        vld;
        logic [9:0]  pco;
        logic        busy;
        logic        halted;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(input logic st, input logic [1:0] sel, input logic stl,
                                input logic br, input logic [15:0] off, input logic jmp,
                                input logic [9:0] jt, input logic ca, input logic [9:0] addr,
                                input logic vld, input logic [9:0] pco, input logic busy,
                                input logic halted);
        vec_t v;
        v.start = st; v.sel = sel; v.stall = stl; v.br = br; v.off = off;
        v.jmp = jmp; v.jt = jt; v.ca = ca; v.addr = addr; v.vld = vld;
        v.pco = pco; v.busy = busy; v.halted = halted;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic st, input logic [1:0] sel, input logic stl, input logic br,
                       input logic [15:0] off, input logic jmp, input logic [9:0] jt);
        bus.start = st; bus.prog_sel = sel; bus.stall = stl; bus.branch_taken = br;
        bus.branch_offset = off; bus.jump = jmp; bus.jump_target = {16'd0, jt};
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_state(input string nm, input logic [9:0] addr, input logic vld,
                             input logic [9:0] pco, input logic busy, input logic halted);
        chk({nm, ".address"}, 32'(bus.address), 32'(addr));
        chk({nm, ".valid"},   32'(bus.valid),   32'(vld));
        chk({nm, ".pc_out"},  32'(bus.pc_out),  32'(pco));
        chk({nm, ".busy"},    32'(bus.busy),    32'(busy));
        chk({nm, ".halted"},  32'(bus.halted),  32'(halted));
        if (vld) chk({nm, ".instr_out"}, bus.instr_out, memword(pco));
    endtask

    task automatic chk_reset(input string nm);
        chk_state(nm, 10'd0, 1'b0, 10'd0, 1'b0, 1'b0);
        chk({nm, ".instr_out"}, bus.instr_out, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //         st sel stl br off       jmp jt    ca addr vld pco busy hlt
        tbl[0]  = mk(1, 0, 0, 0, 16'h0000, 0, 10'd0,   1, 0,   0, 0,  1, 0);
        tbl[1]  = mk(0, 0, 0, 0, 16'h0000, 0, 10'd0,   1, 1,   1, 0,  1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 16'h0000, 0, 10'd0,   1, 2,   1, 1,  1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 16'h0000, 0, 10'd0,   1, 3,   1, 2,  1, 0);
        tbl[4]  = mk(0, 0, 0, 0, 16'h0000, 0, 10'd0,   1, 4,   1, 3,  1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 16'h0000, 0, 10'd0,   1, 5,   1, 4,  1, 0);
        tbl[6]  = mk(0, 0, 0, 0, 16'h0000, 0, 10'd0,   1, 6,   1, 5,  1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 16'h0000, 0, 10'd0,   1, 7,   1, 6,  1, 0);
        tbl[8]  = mk(0, 0, 0, 1, 16'h0015, 0, 10'd0,   1, 28,  0, 6,  1, 0);
        tbl[9]  = mk(0, 0, 0, 0, 16'h0000, 0, 10'd0,   1, 29,  1, 28, 1, 0);
        tbl[10] = mk(0, 0, 0, 0, 16'h0000, 0, 10'd0,   1, 30,  1, 29, 1, 0);
        tbl[11] = mk(0, 0, 1, 0, 16'h0000, 0, 10'd0,   1, 30,  1, 29, 1, 0);
        tbl[12] = mk(0, 0, 1, 0, 16'h0000, 0, 10'd0,   1, 30,  1, 29, 1, 0);
        tbl[13] = mk(0, 0, 1, 0, 16'h0000, 0, 10'd0,   1, 30,  1, 29, 1, 0);
        tbl[14] = mk(0, 0, 0, 0, 16'h0000, 0, 10'd0,   1, 31,  1, 30, 1, 0);
        tbl[15] = mk(0, 0, 1, 0, 16'h0000, 1, 10'd15,  1, 15,  0, 30, 1, 0);
        tbl[16] = mk(0, 0, 0, 0, 16'h0000, 0, 10'd0,   1, 16,  1, 15, 1, 0);
        tbl[17] = mk(0, 0, 0, 1, 16'h0005, 1, 10'd40,  1, 40,  0, 15, 1, 0);
        tbl[18] = mk(0, 0, 0, 0, 16'h0000, 0, 10'd0,   1, 41,  1, 40, 1, 0);
        tbl[19] = mk(0, 0, 0, 0, 16'h0000, 1, 10'd2,   1, 2,   0, 40, 1, 0);
        tbl[20] = mk(0, 0, 0, 0, 16'h0000, 1, 10'd50,  1, 3,   1, 2,  1, 0);
        tbl[21] = mk(0, 0, 0, 0, 16'h0000, 1, 10'd6,   1, 6,   0, 2,  1, 0);
        tbl[22] = mk(0, 0, 1, 0, 16'h0000, 0, 10'd0,   1, 6,   0, 2,  1, 0);
        tbl[23] = mk(0, 0, 0, 0, 16'h0000, 0, 10'd0,   1, 7,   1, 6,  1, 0);
        tbl[24] = mk(0, 0, 0, 1, 16'hFFFE, 0, 10'd0,   1, 5,   0, 6,  1, 0);
        tbl[25] = mk(0, 0, 0, 0, 16'h0000, 0, 10'd0,   1, 6,   1, 5,  1, 0);
        tbl[26] = mk(1, 1, 0, 0, 16'h0000, 0, 10'd0,   1, 7,   1, 6,  1, 0);
        tbl[27] = mk(0, 0, 0, 0, 16'h0000, 1, 10'd100, 0, 0,   0, 6,  0, 1);
        tbl[28] = mk(1, 1, 0, 0, 16'h0000, 0, 10'd0,   1, 10,  0, 6,  1, 0);
        tbl[29] = mk(0, 0, 0, 0, 16'h0000, 0, 10'd0,   1, 11,  1, 10, 1, 0);

        // Reset state
        drv(0, 0, 0, 0, 16'h0, 0, 10'd0);
        reset_n = 1'b0;
        step();
        step();
        chk_reset("reset");
        reset_n = 1'b1;
        step();
        chk_reset("idle_no_start");

        for (int i = 0; i < 30; i++) begin
            drv(tbl[i].start, tbl[i].sel, tbl[i].stall, tbl[i].br, tbl[i].off,
                tbl[i].jmp, tbl[i].jt);
            step();
            if (tbl[i].ca)
                chk($sformatf("row%0d.address", i), 32'(bus.address), 32'(tbl[i].addr));
            chk($sformatf("row%0d.valid", i),  32'(bus.valid),  32'(tbl[i].vld));
            chk($sformatf("row%0d.pc_out", i), 32'(bus.pc_out), 32'(tbl[i].pco));
            chk($sformatf("row%0d.busy", i),   32'(bus.busy),   32'(tbl[i].busy));
            chk($sformatf("row%0d.halted", i), 32'(bus.halted), 32'(tbl[i].halted));
            if (tbl[i].vld)
                chk($sformatf("row%0d.instr_out", i), bus.instr_out, memword(tbl[i].pco));
        end
        drv(0, 0, 0, 0, 16'h0, 0, 10'd0);

        // Program 1: run to pc_out=20, then jump back to 15 with a single bubble
        for (int k = 11; k <= 20; k++) begin
            step();
            chk_state($sformatf("p1_run%0d", k), 10'(k + 1), 1'b1, 10'(k), 1'b1, 1'b0);
        end
        drv(0, 0, 0, 0, 16'h0, 1, 10'd15);
        step();
        chk_state("p1_jump", 10'd15, 1'b0, 10'd20, 1'b1, 1'b0);
        drv(0, 0, 0, 0, 16'h0, 0, 10'd0);
        step();
        chk_state("p1_after_jump", 10'd16, 1'b1, 10'd15, 1'b1, 1'b0);

        // Overrun: last word 80 delivered, then halt with pc holding 81
        for (int k = 16; k <= 80; k++) begin
            step();
            chk_state($sformatf("run%0d", k), 10'(k + 1), 1'b1, 10'(k), 1'b1, 1'b0);
        end
        step();
        chk_state("overrun_halt", 10'd81, 1'b0, 10'd80, 1'b0, 1'b1);
        step();
        chk_state("halt_hold", 10'd81, 1'b0, 10'd80, 1'b0, 1'b1);
        drv(1, 2, 0, 0, 16'h0, 0, 10'd0);
        step();
        chk_state("restart_p2", 10'd21, 1'b0, 10'd80, 1'b1, 1'b0);
        drv(0, 0, 0, 0, 16'h0, 0, 10'd0);
        step();
        chk_state("p2_first", 10'd22, 1'b1, 10'd21, 1'b1, 1'b0);

        // Reset while fetching at address 7
        drv(0, 0, 0, 0, 16'h0, 1, 10'd6);
        step();
        chk_state("to6", 10'd6, 1'b0, 10'd21, 1'b1, 1'b0);
        drv(0, 0, 0, 0, 16'h0, 0, 10'd0);
        step();
        chk_state("at7", 10'd7, 1'b1, 10'd6, 1'b1, 1'b0);
        reset_n = 1'b0;
        step();
        chk_reset("midrun_reset");
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_reset($sformatf("post_reset_idle%0d", k));
        end
        drv(1, 3, 0, 0, 16'h0, 0, 10'd0);
        step();
        chk_state("start_p3", 10'd0, 1'b0, 10'd0, 1'b1, 1'b0);
`ifdef IFETCH_PERF_COUNT_EN
        chk("fetch_count_clr",  32'(fetch_count),  32'd0);
        chk("bubble_count_clr", 32'(bubble_count), 32'd0);
`endif
        drv(0, 0, 0, 0, 16'h0, 0, 10'd0);
        step();
        chk_state("p3_first", 10'd1, 1'b1, 10'd0, 1'b1, 1'b0);
`ifdef IFETCH_PERF_COUNT_EN
        chk("fetch_count_one", 32'(fetch_count), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
